triple_serializer: RTL

Sequential transmitter for the pair/triple voting datapath. It accepts one 3-bit triple (`in0`, `in1`, `in2`) per input handshake, holds it in a register, and sends it one bit per beat over a 1-bit valid/ready output stream. It can append a fourth beat carrying the pair/triple vote, which is 1 when at least two of the three bits are 1. It sits between a parallel producer and any serial consumer of voted triples.

---
 rtl/triple_serializer_pkg.sv | 17 +
 rtl/pair_triple_vote.sv | 14 +
 rtl/triple_serializer.sv | 106 ++++++++++
 3 files changed

// File: rtl/triple_serializer_pkg.sv
// rtl/triple_serializer_pkg.sv - shared state encoding and frame constants for triple_serializer
package triple_serializer_pkg;

    // The encoding is chosen so that each data state equals its 1-based beat
    // number; the final-beat state of a frame is therefore its frame length.
    typedef enum logic [2:0] {
        STATE_IDLE = 3'd0,
        STATE_BIT0 = 3'd1,
        STATE_BIT1 = 3'd2,
        STATE_BIT2 = 3'd3,
        STATE_VOTE = 3'd4
    } state_e;

    localparam int FRAME_LEN_VOTE   = 4;
    localparam int FRAME_LEN_NOVOTE = 3;

endpackage

// File: rtl/pair_triple_vote.sv
// rtl/pair_triple_vote.sv - combinational 3-input pair/triple majority vote
// Ports:
//   a_i, b_i, c_i : triple bits
//   vote_o        : 1 when at least two inputs are 1 (gate-level X semantics)
module pair_triple_vote (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic vote_o
);

    assign vote_o = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);

endmodule

// File: rtl/triple_serializer.sv
// rtl/triple_serializer.sv - serializes a latched 3-bit triple (plus optional vote) onto a 1-bit stream
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   istream_val / istream_rdy    : input triple handshake
//   in0, in1, in2                : triple bits, sampled on input handshake
//   ostream_val / ostream_rdy    : output beat handshake
//   ostream_data                 : beat payload
//   ostream_first / ostream_last : frame delimiters
module triple_serializer
    import triple_serializer_pkg::*;
#(
    parameter bit p_emit_vote = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic istream_val,
    output logic istream_rdy,
    input  logic in0,
    input  logic in1,
    input  logic in2,
    output logic ostream_val,
    input  logic ostream_rdy,
    output logic ostream_data,
    output logic ostream_first,
    output logic ostream_last
);

    localparam int          FRAME_LEN  = p_emit_vote ? FRAME_LEN_VOTE : FRAME_LEN_NOVOTE;
    localparam logic [2:0]  LAST_STATE = 3'(FRAME_LEN);

    state_e     state_q, state_d;
    logic [2:0] triple_q, triple_d;
    logic       vote;

    pair_triple_vote u_vote (
        .a_i    (triple_q[0]),
        .b_i    (triple_q[1]),
        .c_i    (triple_q[2]),
        .vote_o (vote)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= STATE_IDLE;
            triple_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            triple_q <= triple_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        triple_d      = triple_q;
        istream_rdy   = 1'b0;
        ostream_val   = 1'b0;
        ostream_data  = 1'b0;
        ostream_first = 1'b0;
        ostream_last  = 1'b0;

        case (state_q)
            STATE_IDLE: begin
                istream_rdy = 1'b1;
                if (istream_val) begin
                    triple_d = {in2, in1, in0};
                    state_d  = STATE_BIT0;
                end
            end
            STATE_BIT0: begin
                ostream_val   = 1'b1;
                ostream_data  = triple_q[0];
                ostream_first = 1'b1;
                if (ostream_rdy) state_d = STATE_BIT1;
            end
            STATE_BIT1: begin
                ostream_val  = 1'b1;
                ostream_data = triple_q[1];
                if (ostream_rdy) state_d = STATE_BIT2;
            end
            STATE_BIT2: begin
                ostream_val  = 1'b1;
                ostream_data = triple_q[2];
                if (ostream_rdy) state_d = p_emit_vote ? STATE_VOTE : STATE_IDLE;
            end
            STATE_VOTE: begin
                ostream_val  = 1'b1;
                ostream_data = vote;
                if (ostream_rdy) state_d = STATE_IDLE;
            end
            default: state_d = STATE_IDLE;
        endcase

        ostream_last = (state_q == LAST_STATE);

        // Reset forces every output quiet on the reset cycle itself, even when
        // the register still holds a mid-frame state.
        if (rst) begin
            istream_rdy   = 1'b0;
            ostream_val   = 1'b0;
            ostream_data  = 1'b0;
            ostream_first = 1'b0;
            ostream_last  = 1'b0;
        end
    end

endmodule
